// File: rtl/pin_monitor_pkg.sv
// pin_monitor_pkg: shared constants and event record layout helpers for the pin monitor
package pin_monitor_pkg;

    localparam int ARM_CYCLES = 3;
    localparam int TIME_LSB   = 0;

    function automatic int state_lsb(input int ts_w);
        return ts_w;
    endfunction

    function automatic int mask_lsb(input int width, input int ts_w);
        return ts_w + width;
    endfunction

endpackage

// File: rtl/pin_monitor_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with extra-MSB pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd, do_wr;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rp[AW-1:0]];

    // storage: data needs no reset, emptiness is carried by the pointers
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp[AW-1:0]] <= wr_data;
    end

    // pointers: a pop on a full FIFO frees the slot the same-cycle push lands in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/pin_monitor.sv
// pin_monitor: synchronises input pins, timestamps every change and queues it as an event
module pin_monitor
    import pin_monitor_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_pins,
    input  logic             event_ready,
    input  logic             clear_overflow,
    output logic             event_valid,
    output logic [WIDTH-1:0] event_mask,
    output logic [WIDTH-1:0] event_state,
    output logic [TS_W-1:0]  event_time,
    output logic             overflow,
    output logic [WIDTH-1:0] current_pins
);

    localparam int EW  = 2 * WIDTH + TS_W;
    localparam int MSB = mask_lsb(WIDTH, TS_W);
    localparam int SSB = state_lsb(TS_W);

    logic [WIDTH-1:0] s1, s2, prev, chg;
    logic [TS_W-1:0]  ts;
    logic [1:0]       arm;
    logic             armed, push, pop, full, empty;
    logic [EW-1:0]    wr_data, rd_data;

    assign chg          = s2 ^ prev;
    assign armed        = arm == 2'(ARM_CYCLES);
    assign push         = armed && |chg;
    assign pop          = event_valid && event_ready;
    assign wr_data      = {chg, s2, ts};
    assign event_valid  = !empty;
    assign event_mask   = event_valid ? rd_data[MSB +: WIDTH] : '0;
    assign event_state  = event_valid ? rd_data[SSB +: WIDTH] : '0;
    assign event_time   = event_valid ? rd_data[TIME_LSB +: TS_W] : '0;
    assign current_pins = s2;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (event_ready),
        .rd_data (rd_data),
        .empty   (empty)
    );

    // sync chain, change history, timestamp, arming and sticky overflow (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            ts       <= '0;
            arm      <= '0;
            overflow <= 1'b0;
        end else begin
            s1       <= input_pins;
            s2       <= s1;
            prev     <= s2;
            ts       <= ts + 1'b1;
            arm      <= armed ? arm : arm + 1'b1;
            overflow <= (push && full && !pop) ? 1'b1 : clear_overflow ? 1'b0 : overflow;
        end
    end

endmodule
